// File: rtl/gray_binary_conv_pipe.sv
// Two-stage Gray<->binary converter with valid/ready handshake.
// Stage 1 captures the word and audits Gray single-bit steps. Stage 2 holds the converted result.
module gray_binary_conv_pipe #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 adv;
  logic                 accept;
  logic                 s1_valid_reg;
  logic                 s1_mode_reg;
  logic [WIDTH-1:0]     s1_data_reg;
  logic                 s1_err_reg;
  logic [WIDTH-1:0]     hist_reg;
  logic                 hist_valid_reg;
  logic                 out_valid_reg;
  logic                 out_mode_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic                 out_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     diff_m1;
  logic                 multi_bit;
  logic                 step_err_next;
  logic [WIDTH-1:0]     g2b;
  logic [WIDTH-1:0]     b2g;
  logic [WIDTH-1:0]     conv_next;

  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  assign diff          = hist_reg ^ in_data;
  assign diff_m1       = diff - {{(WIDTH-1){1'b0}}, 1'b1};
  assign multi_bit     = (diff & diff_m1) != '0;
  assign step_err_next = !in_mode && hist_valid_reg && multi_bit;

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign g2b[gi] = ^s1_data_reg[WIDTH-1:gi];
    end
  endgenerate

  assign b2g       = s1_data_reg ^ (s1_data_reg >> 1);
  assign conv_next = s1_mode_reg ? b2g : g2b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_mode_reg    <= 1'b0;
      s1_data_reg    <= '0;
      s1_err_reg     <= 1'b0;
      hist_reg       <= '0;
      hist_valid_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_mode_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_err_reg    <= 1'b0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s1_mode_reg   <= in_mode;
      s1_data_reg   <= in_data;
      s1_err_reg    <= accept && step_err_next;
      out_valid_reg <= s1_valid_reg;
      out_mode_reg  <= s1_mode_reg;
      out_data_reg  <= conv_next;
      out_err_reg   <= s1_valid_reg && s1_err_reg;
      if (accept) begin
        if (!in_mode) begin
          hist_reg       <= in_data;
          hist_valid_reg <= 1'b1;
        end else begin
          hist_valid_reg <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready && out_err_reg && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_reg;
  assign out_mode  = out_mode_reg;
  assign out_data  = out_data_reg;
  assign step_err  = out_err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
